// File: rtl/data_mem_if.sv
// data_mem_if: load/store bus between the core and the data-memory responder
interface data_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        align_err;
  modport master (output mem_read, mem_write, address, write_data,
                  input  read_data, stall, done, align_err);
  modport slave  (input  mem_read, mem_write, address, write_data,
                  output read_data, stall, done, align_err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-wide data memory with wait states, stall and done pulse
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              state, next;
  logic [3:0]          cnt;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic [31:0]         mem [DEPTH];
  logic                req, access, mis;
  logic [ADDR_W-1:0]   idx;
  assign req    = bus.mem_read | bus.mem_write;
  assign mis    = addr_q[1:0] != 2'b00;
  assign idx    = addr_q[ADDR_W+1:2];
  assign access = state == BUSY && cnt == 4'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end
  always_comb begin
    next = state == IDLE ? (req ? BUSY : IDLE)
         : state == BUSY ? (cnt == 4'd0 ? DONE : BUSY)
         : IDLE;
  end
  always_comb begin
    bus.stall     = (state == IDLE && req) || state == BUSY;
    bus.done      = state == DONE;
    bus.align_err = state == DONE && mis;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_q          <= 1'b0;
      bus.read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= 4'(WAIT_STATES);
        addr_q  <= bus.address[ADDR_W+1:0];
        wdata_q <= bus.write_data;
        wr_q    <= bus.mem_write;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !wr_q) bus.read_data <= mis ? 32'h0 : mem[idx];
    end
  end
  // array has no reset; a write aborted by reset never reaches its access edge
  always_ff @(posedge clk) begin
    if (access && wr_q && !mis) mem[idx] <= wdata_q;
  end
endmodule
